// File: rtl/pc_next_unit_if.sv
// Interface bundle between the fetch/next-PC unit and the surrounding core.
// The slave modport is the unit; the master modport is the decode/execute side.
interface pc_next_unit_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              stall;
  logic [25:0]       Instr;
  logic [1:0]        RegDst;
  logic              Branch;
  logic              Zero;
  logic              Jump;
  logic              JumpReg;
  logic [XLEN-1:0]   RegA;
  logic [XLEN-1:0]   PC;
  logic [XLEN-1:0]   PCPlus4;
  logic [XLEN-1:0]   SignImm;
  logic [XLEN-1:0]   PCBranch;
  logic [REG_AW-1:0] WriteReg;
  logic              instr_vld;
  logic              redirect;

  modport slave (
    input  stall, Instr, RegDst, Branch, Zero, Jump, JumpReg, RegA,
    output PC, PCPlus4, SignImm, PCBranch, WriteReg, instr_vld, redirect
  );

  modport master (
    output stall, Instr, RegDst, Branch, Zero, Jump, JumpReg, RegA,
    input  PC, PCPlus4, SignImm, PCBranch, WriteReg, instr_vld, redirect
  );
endinterface

// File: rtl/pc_next_unit.sv
// Fetch/next-PC stage: PC register, branch/jump target generation, destination-register select.
// Define BRANCH_DELAY_SLOT_EN for a MIPS delay slot instead of a one-cycle FLUSH bubble.
module pc_next_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              REG_AW   = 5,
  parameter int              LINK_REG = 31
) (
  input  logic          clk,
  input  logic          reset,
  pc_next_unit_if.slave bus
);

`ifdef BRANCH_DELAY_SLOT_EN
  typedef enum logic [1:0] {BOOT, RUN, FLUSH, DSLOT} state_t;
`else
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
`endif

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4, sign_imm, pc_branch, jta, jrta, target;
  logic            take, redirect, instr_vld;
  logic [REG_AW-1:0] write_reg;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
    return {{(XLEN-16){imm[15]}}, imm};
  endfunction

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

  assign pc_plus4  = pc_q + XLEN'(4);
  assign sign_imm  = sext16(bus.Instr[15:0]);
  assign pc_branch = pc_plus4 + (sign_imm << 2);
  assign jta       = {pc_plus4[XLEN-1:28], bus.Instr, 2'b00};
  assign jrta      = word_align(bus.RegA);
  assign take      = bus.JumpReg | bus.Jump | (bus.Branch & bus.Zero);

  always_comb begin
    target = pc_plus4;
    if (bus.JumpReg)                target = jrta;
    else if (bus.Jump)              target = jta;
    else if (bus.Branch & bus.Zero) target = pc_branch;
  end

  always_comb begin
    write_reg = REG_AW'(bus.Instr[20:16]);
    case (bus.RegDst)
      2'b01:   write_reg = REG_AW'(bus.Instr[15:11]);
      2'b10:   write_reg = REG_AW'(LINK_REG);
      default: write_reg = REG_AW'(bus.Instr[20:16]);
    endcase
  end

`ifdef BRANCH_DELAY_SLOT_EN
  logic [XLEN-1:0] tgt_q, tgt_d;

  // Target captured at redirect so RegA is free to change during the delay slot
  always_ff @(posedge clk) begin
    tgt_q <= tgt_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    redirect  = 1'b0;
    instr_vld = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
    tgt_d     = tgt_q;
`endif
    case (state_q)
      BOOT: begin
        if (!bus.stall) state_d = RUN;
      end
      RUN: begin
        instr_vld = 1'b1;
        if (!bus.stall) begin
          if (take) begin
            redirect = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
            tgt_d    = target;
            pc_d     = pc_plus4;
            state_d  = DSLOT;
`else
            pc_d     = target;
            state_d  = FLUSH;
`endif
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      FLUSH: begin
        if (!bus.stall) begin
          pc_d    = pc_plus4;
          state_d = RUN;
        end
      end
`ifdef BRANCH_DELAY_SLOT_EN
      DSLOT: begin
        instr_vld = 1'b1;
        if (!bus.stall) begin
          pc_d    = tgt_q;
          state_d = RUN;
        end
      end
`endif
      default: state_d = BOOT;
    endcase
  end

  // Reset wins over stall and applies in every state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.PC        = pc_q;
  assign bus.PCPlus4   = pc_plus4;
  assign bus.SignImm   = sign_imm;
  assign bus.PCBranch  = pc_branch;
  assign bus.WriteReg  = write_reg;
  assign bus.instr_vld = instr_vld;
  assign bus.redirect  = redirect;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit (default build: FLUSH bubble after a taken transfer).
module tb_pc_next_unit;
  localparam int XLEN = 32;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        vld;
    logic        red;
    int          xsel;   // 0 none, 1 PCPlus4, 2 PCBranch, 3 SignImm, 4 WriteReg
    logic [31:0] xval;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t sb[$];

  pc_next_unit_if #(.XLEN(XLEN), .REG_AW(5)) bus();

  pc_next_unit #(
    .XLEN(XLEN), .RESET_PC(32'h0040_0000), .REG_AW(5), .LINK_REG(31)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, one queued expectation per cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp({e.name, ".PC"}, bus.PC, e.pc);
        cmp({e.name, ".instr_vld"}, {31'd0, bus.instr_vld}, {31'd0, e.vld});
        cmp({e.name, ".redirect"}, {31'd0, bus.redirect}, {31'd0, e.red});
        case (e.xsel)
          1: cmp({e.name, ".PCPlus4"}, bus.PCPlus4, e.xval);
          2: cmp({e.name, ".PCBranch"}, bus.PCBranch, e.xval);
          3: cmp({e.name, ".SignImm"}, bus.SignImm, e.xval);
          4: cmp({e.name, ".WriteReg"}, {27'd0, bus.WriteReg}, e.xval);
          default: ;
        endcase
      end
    end
  end

  // One cycle of stimulus: ctl = {stall, Branch, Zero, Jump, JumpReg}
  task automatic cyc(input string name, input logic rst, input logic [4:0] ctl,
                     input logic [25:0] instr, input logic [1:0] regdst, input logic [31:0] rega,
                     input logic [31:0] epc, input logic evld, input logic ered,
                     input int xsel, input logic [31:0] xval);
    exp_t e;
    @(posedge clk);
    #1;
    reset       = rst;
    bus.stall   = ctl[4];
    bus.Branch  = ctl[3];
    bus.Zero    = ctl[2];
    bus.Jump    = ctl[1];
    bus.JumpReg = ctl[0];
    bus.Instr   = instr;
    bus.RegDst  = regdst;
    bus.RegA    = rega;
    e.name = name; e.pc = epc; e.vld = evld; e.red = ered; e.xsel = xsel; e.xval = xval;
    sb.push_back(e);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.stall = 1'b0; bus.Branch = 1'b0; bus.Zero = 1'b0; bus.Jump = 1'b0; bus.JumpReg = 1'b0;
    bus.Instr = '0; bus.RegDst = 2'b00; bus.RegA = '0;
    repeat (2) @(posedge clk);

    cyc("boot",       0, 5'b00000, 26'h0,       2'b00, 32'h0,         32'h0040_0000, 0, 0, 1, 32'h0040_0004);
    cyc("run_jr",     0, 5'b00001, 26'h0,       2'b00, 32'h0000_00FF, 32'h0040_0000, 1, 1, 0, 32'h0);
    cyc("flush_ign",  0, 5'b00010, 26'h0,       2'b00, 32'h0,         32'h0000_00FC, 0, 0, 0, 32'h0);
    cyc("br_nt",      0, 5'b01000, 26'h0FFFE,   2'b00, 32'h0,         32'h0000_0100, 1, 0, 2, 32'h0000_00FC);
    cyc("br_t",       0, 5'b01100, 26'h0FFFE,   2'b00, 32'h0,         32'h0000_0104, 1, 1, 2, 32'h0000_0100);
    cyc("flush_simm", 0, 5'b00000, 26'h08000,   2'b00, 32'h0,         32'h0000_0100, 0, 0, 3, 32'hFFFF_8000);
    cyc("jr_prio",    0, 5'b00011, 26'h1,       2'b00, 32'h0000_2003, 32'h0000_0104, 1, 1, 0, 32'h0);
    cyc("flush_2000", 0, 5'b00000, 26'h0,       2'b00, 32'h0,         32'h0000_2000, 0, 0, 1, 32'h0000_2004);
    cyc("jr_top",     0, 5'b00001, 26'h0,       2'b00, 32'hFFFF_FFFC, 32'h0000_2004, 1, 1, 0, 32'h0);
    cyc("wrap",       0, 5'b00000, 26'h0,       2'b00, 32'h0,         32'hFFFF_FFFC, 0, 0, 1, 32'h0);
    cyc("run_zero",   0, 5'b00001, 26'h0,       2'b00, 32'h8FFF_FFFC, 32'h0000_0000, 1, 1, 0, 32'h0);
    cyc("flush_8ff",  0, 5'b00000, 26'h0,       2'b00, 32'h0,         32'h8FFF_FFFC, 0, 0, 0, 32'h0);
    cyc("jump_jta",   0, 5'b00010, 26'h1,       2'b00, 32'h0,         32'h9000_0000, 1, 1, 0, 32'h0);
    cyc("flush_jta",  0, 5'b00000, 26'h0,       2'b00, 32'h0,         32'h9000_0004, 0, 0, 0, 32'h0);
    cyc("stall1",     0, 5'b10010, 26'h10,      2'b00, 32'h0,         32'h9000_0008, 1, 0, 0, 32'h0);
    cyc("stall2",     0, 5'b10010, 26'h10,      2'b00, 32'h0,         32'h9000_0008, 1, 0, 0, 32'h0);
    cyc("stall3",     0, 5'b10010, 26'h10,      2'b00, 32'h0,         32'h9000_0008, 1, 0, 0, 32'h0);
    cyc("unstall_j",  0, 5'b00010, 26'h10,      2'b00, 32'h0,         32'h9000_0008, 1, 1, 0, 32'h0);
    cyc("rst_flush",  1, 5'b10000, 26'h0,       2'b00, 32'h0,         32'h9000_0040, 0, 0, 0, 32'h0);
    cyc("boot2_link", 0, 5'b00001, 26'h0,       2'b10, 32'h0000_1234, 32'h0040_0000, 0, 0, 4, 32'd31);
    cyc("wr_rd",      0, 5'b10000, 26'h04800,   2'b01, 32'h0,         32'h0040_0000, 1, 0, 4, 32'd9);
    cyc("wr_rt",      0, 5'b10000, 26'h70000,   2'b00, 32'h0,         32'h0040_0000, 1, 0, 4, 32'd7);
    cyc("wr_rt11",    0, 5'b10000, 26'h70000,   2'b11, 32'h0,         32'h0040_0000, 1, 0, 4, 32'd7);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #2;
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
